mdu_sequencer: RTL and testbench

- Iterative multi-cycle controller and datapath for RV32M multiply/divide ops in the EX stage.
- Replaces the single-cycle M-extension ALU path for these ops.
- Accepts an M-op from ID/EX and holds the pipeline via `stall` while it runs shift-add multiply or restoring divide over XLEN iterations.
- Presents a registered result for one cycle, which EX/MEM captures.

---
 rtl/mdu_sequencer.sv | 100 ++++++++++
 tb/tb_mdu_sequencer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative RV32M multiply/divide with pipeline stall; define MDU_FAST_MUL_EN for single-cycle multiplies.
module mdu_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [CNT_W-1:0] counter;
  logic [2:0] op;
  logic neg_a, neg_b, sgn_a, sgn_b, div_zero, div_ovf;
  logic [XLEN-1:0] mag_b, abs_a, abs_b, special, quo, rem, fin;
  // acc is {partial product, multiplier} for multiply and {remainder, quotient} for divide
  logic [2*XLEN-1:0] acc, acc_n, prod;
  logic [XLEN:0] sum, trial;
`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fprod;
  logic [XLEN-1:0] fres;
`endif
  always_comb begin
    sgn_b = op_b[XLEN-1] & (funct3 == 3'd0 | funct3 == 3'd1 | funct3 == 3'd4 | funct3 == 3'd6);
    sgn_a = op_a[XLEN-1] & (funct3 == 3'd0 | funct3 == 3'd1 | funct3 == 3'd2 | funct3 == 3'd4 | funct3 == 3'd6);
    abs_a = sgn_a ? -op_a : op_a;
    abs_b = sgn_b ? -op_b : op_b;
    div_zero = funct3[2] & (op_b == '0);
    div_ovf = (funct3 == 3'd4 | funct3 == 3'd6) & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (&op_b);
    special = div_zero ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : op_a);
    sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_b} : '0);
    trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]} - {1'b0, mag_b};
    acc_n = op[2] ? (trial[XLEN] ? {acc[2*XLEN-2:0], 1'b0} : {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1})
                  : {sum, acc[XLEN-1:1]};
    prod = (neg_a ^ neg_b) ? -acc_n : acc_n;
    quo = (neg_a ^ neg_b) ? -acc_n[XLEN-1:0] : acc_n[XLEN-1:0];
    rem = neg_a ? -acc_n[2*XLEN-1:XLEN] : acc_n[2*XLEN-1:XLEN];
    fin = op[2] ? (op[1] ? rem : quo) : (op == 3'd0 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
`ifdef MDU_FAST_MUL_EN
    fprod = {{XLEN{sgn_a}}, op_a} * {{XLEN{sgn_b}}, op_b};
    fres = funct3 == 3'd0 ? fprod[XLEN-1:0] : fprod[2*XLEN-1:XLEN];
`endif
  end
  assign stall = ~flush & ((state == IDLE & start) | state == BUSY);
  assign busy = state != IDLE;
  assign result_valid = state == DONE;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      counter <= '0;
      op <= '0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      mag_b <= '0;
      acc <= '0;
      result <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (start) begin
          op <= funct3;
          neg_a <= sgn_a;
          neg_b <= sgn_b;
          mag_b <= abs_b;
          acc <= {{XLEN{1'b0}}, abs_a};
          counter <= '0;
          if (div_zero | div_ovf) begin
            result <= special;
            state <= DONE;
          end
`ifdef MDU_FAST_MUL_EN
          else if (!funct3[2]) begin
            result <= fres;
            state <= DONE;
          end
`endif
          else state <= BUSY;
        end
        BUSY: begin
          acc <= acc_n;
          counter <= counter + 1'b1;
          if (counter == CNT_W'(XLEN-1)) begin
            result <= fin;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed self-checking bench for mdu_sequencer (iterative or MDU_FAST_MUL_EN build).
module tb_mdu_sequencer;
  logic clk = 0, reset = 0, start = 0, flush = 0;
  logic [2:0] funct3 = 0;
  logic [31:0] op_a = 0, op_b = 0;
  logic stall, busy, result_valid;
  logic [31:0] result;
  int compared = 0, mismatched = 0;
`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  mdu_sequencer dut (.clk(clk), .reset(reset), .start(start), .funct3(funct3), .op_a(op_a),
    .op_b(op_b), .flush(flush), .stall(stall), .busy(busy), .result_valid(result_valid), .result(result));

  always #5 clk = ~clk;

  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output int st, output int vat, output int vcnt);
    @(negedge clk);
    funct3 = f; op_a = a; op_b = b; start = 1; st = 0; vat = -1; vcnt = 0; r = 'x;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (stall) st++;
      if (result_valid) begin vcnt++; vat = c; r = result; start = 0; end
      @(negedge clk);
    end
    start = 0;
  endtask

  task automatic test_reset;
    @(negedge clk); #1;
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL rst_busy got %b want 0", busy); end
    compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL rst_stall got %b want 0", stall); end
    compared++; if (result_valid !== 1'b0) begin mismatched++; $display("FAIL rst_valid got %b want 0", result_valid); end
    compared++; if (result !== 32'h0) begin mismatched++; $display("FAIL rst_result got %h want 0", result); end
    reset = 1;
  endtask

  task automatic test_mul;
    logic [2:0] f[3] = '{3'd0, 3'd1, 3'd2};
    logic [31:0] a[3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
    logic [31:0] b[3] = '{32'd7, 32'd7, 32'hFFFF_FFFF};
    logic [31:0] e[3] = '{32'hFFFF_FFEB, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] r; int st, vat, vcnt;
    for (int i = 0; i < 3; i++) begin
      do_op(f[i], a[i], b[i], r, st, vat, vcnt);
      compared++; if (r !== e[i]) begin mismatched++; $display("FAIL mul%0d_result got %h want %h", i, r, e[i]); end
      compared++; if (st !== MUL_LAT) begin mismatched++; $display("FAIL mul%0d_stall got %0d want %0d", i, st, MUL_LAT); end
      compared++; if (vat !== MUL_LAT || vcnt !== 1) begin mismatched++; $display("FAIL mul%0d_valid got at %0d x%0d want at %0d x1", i, vat, vcnt, MUL_LAT); end
    end
  endtask

  task automatic test_div;
    logic [2:0] f[4] = '{3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] a[4] = '{32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'd20, 32'd20};
    logic [31:0] e[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd3, 32'd2};
    logic [31:0] r; int st, vat, vcnt;
    for (int i = 0; i < 4; i++) begin
      do_op(f[i], a[i], 32'd6, r, st, vat, vcnt);
      compared++; if (r !== e[i]) begin mismatched++; $display("FAIL div%0d_result got %h want %h", i, r, e[i]); end
      compared++; if (st !== 33 || vat !== 33 || vcnt !== 1) begin mismatched++; $display("FAIL div%0d_timing got stall %0d valid at %0d x%0d want 33 33 x1", i, st, vat, vcnt); end
    end
  endtask

  task automatic test_special;
    logic [2:0] f[5] = '{3'd5, 3'd7, 3'd4, 3'd6, 3'd4};
    logic [31:0] a[5] = '{32'd123, 32'd123, 32'h8000_0000, 32'h8000_0000, 32'd55};
    logic [31:0] b[5] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] e[5] = '{32'hFFFF_FFFF, 32'd123, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] r; int st, vat, vcnt;
    for (int i = 0; i < 5; i++) begin
      do_op(f[i], a[i], b[i], r, st, vat, vcnt);
      compared++; if (r !== e[i]) begin mismatched++; $display("FAIL spc%0d_result got %h want %h", i, r, e[i]); end
      compared++; if (st !== 1 || vat !== 1 || vcnt !== 1) begin mismatched++; $display("FAIL spc%0d_timing got stall %0d valid at %0d x%0d want 1 1 x1", i, st, vat, vcnt); end
    end
  endtask

  task automatic test_reset_mid;
    int vcnt = 0;
    @(negedge clk);
    funct3 = 3'd4; op_a = 32'd100; op_b = 32'd7; start = 1;
    repeat (5) @(negedge clk);
    reset = 0; start = 0;
    @(negedge clk); #1;
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL midrst_busy got %b want 0", busy); end
    compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL midrst_stall got %b want 0", stall); end
    compared++; if (result_valid !== 1'b0) begin mismatched++; $display("FAIL midrst_valid got %b want 0", result_valid); end
    compared++; if (result !== 32'h0) begin mismatched++; $display("FAIL midrst_result got %h want 0", result); end
    reset = 1;
    for (int c = 0; c < 40; c++) begin @(negedge clk); #1; if (result_valid) vcnt++; end
    compared++; if (vcnt !== 0) begin mismatched++; $display("FAIL midrst_pulses got %0d want 0", vcnt); end
  endtask

  task automatic test_flush;
    logic [31:0] r; int st, vat, vcnt;
    do_op(3'd7, 32'd20, 32'd6, r, st, vat, vcnt);
    compared++; if (r !== 32'd2) begin mismatched++; $display("FAIL fl_pre got %h want 2", r); end
    @(negedge clk);
    funct3 = 3'd5; op_a = 32'd1000; op_b = 32'd7; start = 1;
    repeat (11) @(negedge clk);
    flush = 1; start = 0; #1;
    compared++; if (stall !== 1'b0 || busy !== 1'b1) begin mismatched++; $display("FAIL fl_stall got stall %b busy %b want 0 1", stall, busy); end
    @(negedge clk);
    flush = 0; #1;
    compared++; if (busy !== 1'b0 || result_valid !== 1'b0) begin mismatched++; $display("FAIL fl_idle got busy %b valid %b want 0 0", busy, result_valid); end
    compared++; if (result !== 32'd2) begin mismatched++; $display("FAIL fl_hold got %h want 2", result); end
    do_op(3'd3, 32'hFFFF_FFFF, 32'd2, r, st, vat, vcnt);
    compared++; if (r !== 32'd1 || vcnt !== 1) begin mismatched++; $display("FAIL fl_mulhu got %h x%0d want 1 x1", r, vcnt); end
  endtask

  task automatic test_back_to_back;
    int n = 0;
    int v[2] = '{-1, -1};
    logic [31:0] r[2] = '{'x, 'x};
    @(negedge clk);
    funct3 = 3'd0; op_a = 32'd5; op_b = 32'd6; start = 1;
    for (int c = 0; c < 100 && n < 2; c++) begin
      #1;
      if (result_valid) begin
        v[n] = c; r[n] = result; n++;
        op_a = 32'd7; op_b = 32'd8;
        if (n == 2) start = 0;
      end
      @(negedge clk);
    end
    start = 0;
    compared++; if (r[0] !== 32'd30 || v[0] !== MUL_LAT) begin mismatched++; $display("FAIL b2b_first got %h at %0d want 0000001e at %0d", r[0], v[0], MUL_LAT); end
    compared++; if (r[1] !== 32'd56 || v[1] !== 2*MUL_LAT + 1) begin mismatched++; $display("FAIL b2b_second got %h at %0d want 00000038 at %0d", r[1], v[1], 2*MUL_LAT + 1); end
  endtask

  initial begin
    test_reset;
    test_mul;
    test_reset_mid;
    test_div;
    test_special;
    test_flush;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
